// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//
// Two-entry elastic pipeline register (skid buffer) with a valid/ready
// handshake on both sides. Every output is driven straight from a flop:
// i_ready depends only on the skid entry and o_valid/o_data only on the
// main entry. There is therefore no combinational path from o_ready to
// i_ready or from i_valid to o_valid, and one transfer per cycle is
// still possible while the downstream keeps o_ready high.
//
// Parameters:
//   DW       payload width in bits (default 32)
//
// Ports:
//   clk      clock, rising-edge active
//   rst_n    asynchronous active-low reset; clears both entries at once
//   i_valid  upstream presents a payload
//   i_ready  buffer can accept (registered, equals ~skid_valid)
//   i_data   upstream payload
//   o_valid  buffer presents a payload downstream (registered)
//   o_ready  downstream accepts
//   o_data   downstream payload, taken directly from the main register
//   flush    synchronous flush; exists only with PIPE_SKID_FLUSH_EN
//
// Build option:
//   PIPE_SKID_FLUSH_EN  when defined, adds the flush port. A flush clears
//                       both valid bits, leaves the data registers alone,
//                       and takes priority over any accept or pop in the
//                       same cycle.
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    // The state is encoded as {skid_valid, main_valid}, so it is just a view
    // of the two valid bits and there is no separate state register.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_BUSY    = 2'b01,
        ST_ILLEGAL = 2'b10,
        ST_FULL    = 2'b11
    } state_e;

    logic          r_main_valid;
    logic [DW-1:0] r_main_data;
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;

    state_e        w_state;
    logic          w_acc;
    logic          w_pop;

    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;
    assign i_ready = ~r_skid_valid;

    assign w_state = state_e'({r_skid_valid, r_main_valid});
    assign w_acc   = i_valid & i_ready;
    assign w_pop   = r_main_valid & o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, so o_data reads 0
            // rather than X after reset and downstream logic never sees X.
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
`ifdef PIPE_SKID_FLUSH_EN
        end else if (flush) begin
            // A flush drops both entries. The data registers keep their
            // contents because they are don't-care while their valid is low.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every branch read the
            // state from before this edge, e.g. main <- skid below uses the
            // old skid_data.
            case (w_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= i_data;
                    end
                end
                ST_BUSY: begin
                    if (w_acc && w_pop) begin
                        // Pass-through: the new payload replaces the one leaving.
                        r_main_data <= i_data;
                    end else if (w_acc) begin
                        // Downstream stalled: park the new payload in the skid entry.
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= i_data;
                    end else if (w_pop) begin
                        r_main_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // i_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_main_data  <= r_skid_data;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    // ST_ILLEGAL cannot be reached. If it ever is, drop both
                    // entries so the buffer returns to a known state.
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_buf
//
// Self-checking bench for pipe_skid_buf (DW = 32). Inputs are driven 1 ns
// after a rising edge and outputs are sampled 1 ns after the next rising
// edge. The randomized section compares the DUT against a two-slot FIFO
// model. Define PIPE_SKID_FLUSH_EN to also exercise the flush port.
// -----------------------------------------------------------------------------
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
`ifdef PIPE_SKID_FLUSH_EN
    logic          flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipe_skid_buf #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs held for one edge, then the outputs expected after
    // that edge. exp_data is compared only when exp_ovalid is 1.
    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_ovalid;
        logic [31:0] exp_data;
        logic        exp_iready;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void add(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic ev, input logic [31:0] ed, input logic er);
        vec_t v;
        v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
        v.exp_ovalid = ev; v.exp_data = ed; v.exp_iready = er;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy);
        i_valid = iv;
        i_data  = id;
        o_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
`ifdef PIPE_SKID_FLUSH_EN
        flush = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Two-slot FIFO reference model.
    logic [31:0] mq[$];

    initial begin
        logic        acc;
        logic        pop;
        logic        hold;
        logic        fl;
        logic [31:0] d;

        // ---------------- vector table ----------------
        // Streaming: 0x1..0x8 back to back with o_ready high.
        for (int k = 1; k <= 8; k++) add(1, k, 1, 1, k, 1);
        add(0, 0, 1, 0, 0, 1);                  // last one drains
        // Stall/skid: 0xA and 0xB are absorbed, 0xC is held upstream.
        add(1, 32'hA, 0, 1, 32'hA, 1);
        add(1, 32'hB, 0, 1, 32'hA, 0);          // full, i_ready low
        add(1, 32'hC, 0, 1, 32'hA, 0);          // 0xC is not taken
        add(1, 32'hC, 1, 1, 32'hB, 1);          // pop A, B moves up
        add(1, 32'hC, 1, 1, 32'hC, 1);          // pop B, accept C
        add(0, 0, 1, 0, 0, 1);                  // pop C -> empty
        // Drain: a single 0x5.
        add(1, 32'h5, 1, 1, 32'h5, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);

        // ---------------- reset state ----------------
        rst_n = 1'b1;
        do_reset();
        check("reset_o_valid", {31'b0, o_valid}, 32'h0);
        check("reset_i_ready", {31'b0, i_ready}, 32'h1);
        check("reset_o_data", o_data, 32'h0);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            tick();
            check($sformatf("vec%0d_o_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].exp_ovalid});
            check($sformatf("vec%0d_i_ready", i), {31'b0, i_ready}, {31'b0, vecs[i].exp_iready});
            if (vecs[i].exp_ovalid)
                check($sformatf("vec%0d_o_data", i), o_data, vecs[i].exp_data);
        end

        // ---------------- asynchronous reset while FULL ----------------
        drive(1, 32'h21, 0); tick();
        drive(1, 32'h22, 0); tick();
        check("pre_reset_full", {31'b0, i_ready}, 32'h0);
        #2 rst_n = 1'b0;                        // mid-cycle, no edge
        #1;
        check("async_rst_o_valid", {31'b0, o_valid}, 32'h0);
        check("async_rst_i_ready", {31'b0, i_ready}, 32'h1);
        check("async_rst_o_data", o_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h11, 0);
        tick();
        check("post_rst_o_valid", {31'b0, o_valid}, 32'h1);
        check("post_rst_o_data", o_data, 32'h11);

`ifdef PIPE_SKID_FLUSH_EN
        // ---------------- flush while FULL, with a pop in the same cycle ----------------
        do_reset();
        drive(1, 32'h1, 0); tick();
        drive(1, 32'h2, 0); tick();
        flush = 1'b1;
        drive(0, 32'h0, 1);
        tick();
        flush = 1'b0;
        check("flush_o_valid", {31'b0, o_valid}, 32'h0);
        check("flush_i_ready", {31'b0, i_ready}, 32'h1);
        drive(1, 32'h3, 0); tick();
        check("post_flush_o_data", o_data, 32'h3);
        check("post_flush_i_ready", {31'b0, i_ready}, 32'h1);
`endif

        // ---------------- randomized stall against the FIFO model ----------------
        do_reset();
        mq.delete();
        hold = 1'b0;
        d    = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            // Keep a refused payload stable until it is taken.
            if (!hold) begin
                i_valid = ($urandom_range(0, 3) != 0);
                d       = $urandom();
            end
            i_data  = d;
            o_ready = ($urandom_range(0, 2) != 0);
            fl      = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
            fl    = ($urandom_range(0, 63) == 0);
            flush = fl;
`endif
            acc = i_valid && (mq.size() < 2);
            pop = o_ready && (mq.size() > 0);
            tick();
            if (fl) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(d);
            end
            hold = i_valid && !acc;
            check("rnd_o_valid", {31'b0, o_valid}, {31'b0, (mq.size() > 0)});
            check("rnd_i_ready", {31'b0, i_ready}, {31'b0, (mq.size() < 2)});
            if (mq.size() > 0) check("rnd_o_data", o_data, mq[0]);
        end
`ifdef PIPE_SKID_FLUSH_EN
        flush = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buf.md
# pipe_skid_buf

Two-entry elastic pipeline register with valid/ready handshake on both sides, placed between core pipeline stages (e.g. fetch → decode, decode → execute). Both outputs toward the upstream and downstream are registered, which breaks the combinational ready path between stages while sustaining one transfer per cycle. It replaces bare load-enabled stage registers wherever the downstream stage can stall.

## Interface
Parameters:
- DW, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream presents a payload.
- i_ready  output  1  buffer can accept; registered, equals NOT skid_valid.
- i_data  input  DW  upstream payload.
- o_valid  output  1  buffer presents a payload downstream; registered.
- o_ready  input  1  downstream accepts.
- o_data  output  DW  downstream payload; driven directly from the main register.
- flush  input  1  synchronous pipeline flush; present only when PIPE_SKID_FLUSH_EN is defined.

## Operation
- Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data).
- o_valid = main_valid, o_data = main_data, i_ready = ~skid_valid.
- Accept (acc) = i_valid & i_ready. Pop = o_valid & o_ready.
- States are decoded from the valid bits:
  - EMPTY: no valid bits set.
  - BUSY: main_valid only.
  - FULL: main_valid and skid_valid.
  - skid_valid & ~main_valid is illegal and unreachable.
- EMPTY:
  - acc: main ← i_data, go to BUSY.
  - otherwise: stay in EMPTY.
- BUSY:
  - acc & pop: main ← i_data, stay in BUSY.
  - acc & ~pop: skid ← i_data, go to FULL.
  - ~acc & pop: main_valid ← 0, go to EMPTY.
  - ~acc & ~pop: hold.
- FULL:
  - i_ready = 0, so acc is impossible.
  - pop: main ← skid, skid_valid ← 0, go to BUSY.
  - otherwise: hold.
- Order is strictly FIFO. No payload is dropped or duplicated except by flush.
- Data registers load only on their enable condition. Data is don't-care when the corresponding valid bit is 0, but it is not X after reset.
- Reset: main_valid = skid_valid = 0, main_data = skid_data = 0. Therefore o_valid = 0, o_data = 0 and i_ready = 1 while rst_n is low and after release.
- Reset asserted mid-operation clears both entries immediately, without waiting for a clock edge.

## Timing
- Latency i → o: 1 cycle. A payload accepted at edge N is visible on o_data/o_valid after edge N.
- Throughput: 1 payload per cycle when o_ready is held high.
- With o_ready low, the buffer absorbs 2 payloads. i_ready falls the cycle after the second accept.
- i_ready rises the cycle after a pop in FULL.
- There is no combinational path from o_ready to i_ready, or from i_valid to o_valid.
- An upstream holding i_valid while i_ready = 0 must keep i_data stable; the buffer does not sample it.
- o_data is stable while o_valid & ~o_ready.

## Configuration
- PIPE_SKID_FLUSH_EN defined:
  - The flush port exists.
  - flush high at an edge clears main_valid and skid_valid; data registers are unchanged.
  - flush overrides any simultaneous acc or pop. A handshake completing in the flush cycle is discarded, and the next cycle is EMPTY with i_ready = 1.
- PIPE_SKID_FLUSH_EN undefined:
  - The port is absent and no flush logic is generated.
  - Behaviour is identical to the defined case with flush tied to 0.

## Test plan
- Reset: rst_n low mid-transfer with the buffer FULL → o_valid = 0, i_ready = 1, o_data = 0 immediately. First edge after release with i_valid = 1, i_data = 0x11 → o_valid = 1, o_data = 0x11.
- Streaming: o_ready = 1, i_data = 0x1,0x2,…,0x8 on consecutive cycles → o_data shows 0x1..0x8 one cycle delayed, no bubbles, i_ready stays 1.
- Stall/skid: o_ready = 0, push 0xA, 0xB, 0xC → 0xA and 0xB accepted, i_ready = 0 from the cycle after 0xB. 0xC is held upstream. Raising o_ready → outputs 0xA, 0xB, 0xC in order.
- Drain: single push 0x5 then i_valid = 0, o_ready = 1 → o_valid high for exactly 1 cycle, then EMPTY.
- Random stall: random i_valid/o_ready for 10k cycles against a scoreboard → order preserved, no loss, i_ready == ~skid_valid every cycle.
- Flush (PIPE_SKID_FLUSH_EN defined): FULL with 0x1/0x2, flush = 1 together with o_ready = 1 → next cycle o_valid = 0, i_ready = 1, and 0x1 is not counted as delivered.
